// File: rtl/vanilla_saif_window_ctrl.sv
// Reference-counted owner of the shared SAIF capture window: merges per-core
// trigger start/end pulses into one toggle-start/stop command stream.
//
//   state  | meaning
//   IDLE   | no core active, no report outstanding
//   ACTIVE | window open, toggle tracking running
//   REPORT | stop issued, waiting for report_done_i before re-arming
module vanilla_saif_window_ctrl #(
  parameter int num_cores_p    = 16,
  parameter int cycle_width_p  = 32,
  parameter int window_width_p = 8,
  localparam int cnt_width_lp  = $clog2(num_cores_p + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [num_cores_p-1:0]    start_v_i,
  input  logic [num_cores_p-1:0]    end_v_i,
  input  logic                      report_done_i,
  output logic                      saif_en_o,
  output logic                      toggle_start_o,
  output logic                      toggle_stop_o,
  output logic [num_cores_p-1:0]    active_vec_o,
  output logic [cnt_width_lp-1:0]   active_cnt_o,
  output logic [cycle_width_p-1:0]  window_cycles_o,
  output logic [window_width_p-1:0] window_count_o,
  output logic                      err_double_start_o,
  output logic                      err_orphan_end_o
);

  typedef enum logic [1:0] {IDLE, ACTIVE, REPORT} state_e;

  state_e                  state_r, state_next;
  logic [num_cores_p-1:0]  vec_next;
  logic [cnt_width_lp-1:0] cnt_next;
  logic                    double_hit, orphan_hit;
  logic                    start_cmd, stop_cmd;

  // A simultaneous start and end on one core cancels out and is never an error.
  always_comb begin
    vec_next   = active_vec_o;
    double_hit = 1'b0;
    orphan_hit = 1'b0;
    for (int i = 0; i < num_cores_p; i++) begin
      if (active_vec_o[i]) begin
        if (end_v_i[i] && !start_v_i[i]) vec_next[i] = 1'b0;
        if (start_v_i[i] && !end_v_i[i]) double_hit = 1'b1;
      end else begin
        if (start_v_i[i] && !end_v_i[i]) vec_next[i] = 1'b1;
        if (end_v_i[i] && !start_v_i[i]) orphan_hit = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < num_cores_p; i++) begin
      cnt_next = cnt_next + cnt_width_lp'(vec_next[i]);
    end
  end

  always_comb begin
    state_next = state_r;
    start_cmd  = 1'b0;
    stop_cmd   = 1'b0;
    unique case (state_r)
      IDLE: begin
        if (|vec_next) begin
          state_next = ACTIVE;
          start_cmd  = 1'b1;
        end
      end
      ACTIVE: begin
        if (~|vec_next) begin
          state_next = REPORT;
          stop_cmd   = 1'b1;
        end
      end
      REPORT: begin
        if (report_done_i) begin
          if (|vec_next) begin
            state_next = ACTIVE;
            start_cmd  = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r            <= IDLE;
      saif_en_o          <= 1'b0;
      toggle_start_o     <= 1'b0;
      toggle_stop_o      <= 1'b0;
      active_vec_o       <= '0;
      active_cnt_o       <= '0;
      window_cycles_o    <= '0;
      window_count_o     <= '0;
      err_double_start_o <= 1'b0;
      err_orphan_end_o   <= 1'b0;
    end else begin
      state_r        <= state_next;
      saif_en_o      <= (state_next == ACTIVE);
      toggle_start_o <= start_cmd;
      toggle_stop_o  <= stop_cmd;
      active_vec_o   <= vec_next;
      active_cnt_o   <= cnt_next;
      if (double_hit) err_double_start_o <= 1'b1;
      if (orphan_hit) err_orphan_end_o   <= 1'b1;
      // Counts every edge taken from ACTIVE, including the exit edge.
      if (start_cmd) begin
        window_cycles_o <= '0;
      end else if (state_r == ACTIVE && window_cycles_o != '1) begin
        window_cycles_o <= window_cycles_o + cycle_width_p'(1);
      end
      if (stop_cmd && window_count_o != '1) begin
        window_count_o <= window_count_o + window_width_p'(1);
      end
    end
  end

endmodule

// File: tb/tb_vanilla_saif_window_ctrl.sv
// Bench for vanilla_saif_window_ctrl: directed table, hand sequences, and
// random traffic checked against a behavioural window model.
module tb_vanilla_saif_window_ctrl;
  localparam int N       = 16;
  localparam int CW      = 6;
  localparam int WW      = 4;
  localparam int CYC_MAX = (1 << CW) - 1;
  localparam int WIN_MAX = (1 << WW) - 1;

  logic          clk, reset;
  logic [N-1:0]  start_v, end_v;
  logic          report_done;
  logic          saif_en, toggle_start, toggle_stop;
  logic [N-1:0]  active_vec;
  logic [4:0]    active_cnt;
  logic [CW-1:0] window_cycles;
  logic [WW-1:0] window_count;
  logic          err_double_start, err_orphan_end;

  int total = 0;
  int bad   = 0;

  vanilla_saif_window_ctrl #(
    .num_cores_p(N), .cycle_width_p(CW), .window_width_p(WW)
  ) dut (
    .clk_i(clk), .reset_i(reset), .start_v_i(start_v), .end_v_i(end_v),
    .report_done_i(report_done), .saif_en_o(saif_en),
    .toggle_start_o(toggle_start), .toggle_stop_o(toggle_stop),
    .active_vec_o(active_vec), .active_cnt_o(active_cnt),
    .window_cycles_o(window_cycles), .window_count_o(window_count),
    .err_double_start_o(err_double_start), .err_orphan_end_o(err_orphan_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: set of active cores plus "window open" / "awaiting report" flags.
  bit m_act[N];
  bit m_open, m_wait, m_ts, m_tp, m_ds, m_oe;
  int m_cyc, m_wins, m_cnt;

  typedef struct {
    logic [N-1:0] s;
    logic [N-1:0] e;
    logic         d;
    logic         saif;
    logic         ts;
    logic         tp;
    int           cnt;
    int           wc;
    logic         eds;
    logic         eoe;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic [N-1:0] s, logic [N-1:0] e, logic d,
                              logic saif, logic ts, logic tp, int cnt, int wc,
                              logic eds, logic eoe);
    vec_t v;
    v.s = s; v.e = e; v.d = d; v.saif = saif; v.ts = ts; v.tp = tp;
    v.cnt = cnt; v.wc = wc; v.eds = eds; v.eoe = eoe;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_act[i] = 1'b0;
    m_open = 0; m_wait = 0; m_ts = 0; m_tp = 0; m_ds = 0; m_oe = 0;
    m_cyc = 0; m_wins = 0; m_cnt = 0;
  endtask

  task automatic open_window();
    m_open = 1; m_ts = 1; m_cyc = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] s, input logic [N-1:0] e, input logic d);
    bit nv[N];
    int n;
    n = 0;
    for (int i = 0; i < N; i++) begin
      if (s[i] && !e[i]) begin
        if (m_act[i]) m_ds = 1;
        nv[i] = 1'b1;
      end else if (e[i] && !s[i]) begin
        if (!m_act[i]) m_oe = 1;
        nv[i] = 1'b0;
      end else begin
        nv[i] = m_act[i];
      end
      n += int'(nv[i]);
    end
    m_ts = 0; m_tp = 0;
    if (m_open) begin
      if (m_cyc < CYC_MAX) m_cyc++;
      if (n == 0) begin
        m_open = 0; m_wait = 1; m_tp = 1;
        if (m_wins < WIN_MAX) m_wins++;
      end
    end else if (m_wait) begin
      if (d) begin
        m_wait = 0;
        if (n > 0) open_window();
      end
    end else if (n > 0) begin
      open_window();
    end
    m_act = nv;
    m_cnt = n;
  endtask

  task automatic compare_model();
    logic [N-1:0] pv;
    for (int i = 0; i < N; i++) pv[i] = m_act[i];
    chk("saif_en",       64'(saif_en),          64'(m_open));
    chk("toggle_start",  64'(toggle_start),     64'(m_ts));
    chk("toggle_stop",   64'(toggle_stop),      64'(m_tp));
    chk("active_vec",    64'(active_vec),       64'(pv));
    chk("active_cnt",    64'(active_cnt),       64'(m_cnt));
    chk("window_cycles", 64'(window_cycles),    64'(m_cyc));
    chk("window_count",  64'(window_count),     64'(m_wins));
    chk("err_double",    64'(err_double_start), 64'(m_ds));
    chk("err_orphan",    64'(err_orphan_end),   64'(m_oe));
  endtask

  // Called at a falling edge; returns at the next falling edge after checking.
  task automatic step(input logic [N-1:0] s, input logic [N-1:0] e, input logic d);
    start_v = s; end_v = e; report_done = d;
    @(posedge clk);
    model_edge(s, e, d);
    @(negedge clk);
    start_v = '0; end_v = '0; report_done = 1'b0;
    compare_model();
  endtask

  initial begin
    int saif_hi, stop_n, wins0;
    reset = 1'b1; start_v = '0; end_v = '0; report_done = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare_model();
    reset = 1'b0;

    // Overlapping cores, same-cycle start+end, double start, orphan end.
    tbl.push_back(mk(16'h0001, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1, 0, 1'b0, 1'b0));
    tbl.push_back(mk(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0));
    tbl.push_back(mk(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0));
    tbl.push_back(mk(16'h0020, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2, 0, 1'b0, 1'b0));
    tbl.push_back(mk(16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0));
    tbl.push_back(mk(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0));
    tbl.push_back(mk(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0));
    tbl.push_back(mk(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0));
    tbl.push_back(mk(16'h0000, 16'h0020, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1, 1'b0, 1'b0));
    tbl.push_back(mk(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0));
    tbl.push_back(mk(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0));
    tbl.push_back(mk(16'h0004, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0));
    tbl.push_back(mk(16'h0002, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1, 1, 1'b0, 1'b0));
    tbl.push_back(mk(16'h0002, 16'h0002, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1, 1'b0, 1'b0));
    tbl.push_back(mk(16'h0002, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1, 1'b1, 1'b0));
    tbl.push_back(mk(16'h0000, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1, 0, 2, 1'b1, 1'b0));
    tbl.push_back(mk(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 0, 2, 1'b1, 1'b0));
    tbl.push_back(mk(16'h0000, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2, 1'b1, 1'b1));
    foreach (tbl[k]) begin
      step(tbl[k].s, tbl[k].e, tbl[k].d);
      chk($sformatf("tbl%0d saif_en", k),      64'(saif_en),          64'(tbl[k].saif));
      chk($sformatf("tbl%0d toggle_start", k), 64'(toggle_start),     64'(tbl[k].ts));
      chk($sformatf("tbl%0d toggle_stop", k),  64'(toggle_stop),      64'(tbl[k].tp));
      chk($sformatf("tbl%0d active_cnt", k),   64'(active_cnt),       64'(tbl[k].cnt));
      chk($sformatf("tbl%0d window_count", k), 64'(window_count),     64'(tbl[k].wc));
      chk($sformatf("tbl%0d err_double", k),   64'(err_double_start), 64'(tbl[k].eds));
      chk($sformatf("tbl%0d err_orphan", k),   64'(err_orphan_end),   64'(tbl[k].eoe));
    end

    // Single core window: start, then end ten edges later.
    wins0 = int'(window_count);
    saif_hi = 0; stop_n = 0;
    step(16'h0001, '0, 1'b0);
    saif_hi += int'(saif_en); stop_n += int'(toggle_stop);
    repeat (9) begin
      step('0, '0, 1'b0);
      saif_hi += int'(saif_en); stop_n += int'(toggle_stop);
    end
    step('0, 16'h0001, 1'b0);
    saif_hi += int'(saif_en); stop_n += int'(toggle_stop);
    chk("single window_cycles", 64'(window_cycles), 64'd10);
    chk("single saif_hi", 64'(saif_hi), 64'd10);
    chk("single stop pulses", 64'(stop_n), 64'd1);
    chk("single window_count", 64'(window_count), 64'(wins0 + 1));

    // Start recorded during REPORT only launches after report_done.
    step(16'h0004, '0, 1'b0);
    chk("report start held", 64'(toggle_start), 64'd0);
    chk("report saif low", 64'(saif_en), 64'd0);
    step('0, '0, 1'b1);
    chk("rearm toggle_start", 64'(toggle_start), 64'd1);
    chk("rearm saif_en", 64'(saif_en), 64'd1);
    chk("rearm cycles cleared", 64'(window_cycles), 64'd0);
    step('0, '0, 1'b0);
    chk("rearm cycles 1", 64'(window_cycles), 64'd1);
    step('0, 16'h0004, 1'b0);
    step('0, '0, 1'b1);
    step('0, '0, 1'b1);
    chk("held done idle", 64'(saif_en | toggle_start), 64'd0);

    // Zero-length window still yields a full start/stop pair.
    step(16'h0001, '0, 1'b0);
    chk("zero-len start", 64'(toggle_start), 64'd1);
    step('0, 16'h0001, 1'b0);
    chk("zero-len stop", 64'(toggle_stop), 64'd1);
    chk("zero-len cycles", 64'(window_cycles), 64'd1);
    step('0, '0, 1'b1);

    // Saturation of both counters.
    step(16'h0001, '0, 1'b0);
    repeat (70) step('0, '0, 1'b0);
    chk("cycles saturate", 64'(window_cycles), 64'(CYC_MAX));
    step('0, 16'h0001, 1'b0);
    step('0, '0, 1'b1);
    repeat (16) begin
      step(16'h0100, '0, 1'b0);
      step('0, 16'h0100, 1'b0);
      step('0, '0, 1'b1);
    end
    chk("window_count saturate", 64'(window_count), 64'(WIN_MAX));

    // Async reset between edges while a window is open.
    step(16'h0010, '0, 1'b0);
    step('0, '0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("async saif_en", 64'(saif_en), 64'd0);
    chk("async active_vec", 64'(active_vec), 64'd0);
    chk("async window_count", 64'(window_count), 64'd0);
    @(posedge clk);
    #1;
    chk("async no stop", 64'(toggle_stop), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    compare_model();

    // Random sparse traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] rs, re;
      rs = N'($urandom & $urandom & $urandom);
      re = N'($urandom & $urandom & $urandom);
      step(rs, re, ($urandom_range(0, 2) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
